ni_flit_injector: RTL and testbench

- Network-interface transmit engine. It drains 32-bit words from the NI's gp_fifo instance, frames them into head/body/tail flits, and injects them onto the router input link.
- Downstream flow control is credit-based: one credit per flit buffer slot in the router input port.
- The block is the read side of the NI FIFO. It drives the FIFO's read_en and consumes its data_out/empty outputs.

---
 rtl/ni_flit_injector.sv | 143 ++++++++++++++
 tb/tb_ni_flit_injector.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_flit_injector.sv
// ni_flit_injector: NI transmit engine. Drains gp_fifo words, frames them into
// head/body/tail flits and injects them on the router link under credit flow control.
module ni_flit_injector #(
    parameter int DATA_WIDTH = 32,
    parameter int CREDITS    = 4,
    parameter int CW         = 3,
    parameter int LEN_W      = 8,
    parameter int PKT_CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    input  logic                  credit_in,
    output logic [DATA_WIDTH-1:0] flit_out,
    output logic                  flit_valid,
    output logic [1:0]            flit_type,
    output logic [CW-1:0]         credits,
    output logic                  credit_err,
    output logic                  busy,
    output logic [PKT_CNT_W-1:0]  pkt_count
);

    typedef enum logic {
        ST_HEAD,
        ST_BODY
    } state_t;

    typedef enum logic [1:0] {
        FT_BODY   = 2'b00,
        FT_HEAD   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_t;

    localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] remain_q;
    logic [LEN_W-1:0] remain_d;
    logic             rd_q;
    flit_type_t       type_d;
    flit_type_t       flit_type_q;
    logic             pkt_done;
    logic [LEN_W-1:0] hdr_len;

    assign hdr_len    = fifo_data[DATA_WIDTH-1 -: LEN_W];
    // A credit is reserved at read issue, so a read never outruns router buffer space.
    assign fifo_rd_en = reset & en & ~fifo_empty & (credits != '0);
    assign busy       = (state_q == ST_BODY) | rd_q;
    assign flit_type  = flit_type_q;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        type_d   = FT_BODY;
        pkt_done = 1'b0;
        if (rd_q) begin
            case (state_q)
                ST_HEAD: begin
                    if (hdr_len == '0) begin
                        type_d   = FT_SINGLE;
                        pkt_done = 1'b1;
                    end else begin
                        type_d   = FT_HEAD;
                        remain_d = hdr_len;
                        state_d  = ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (remain_q == LEN_W'(1)) begin
                        type_d   = FT_TAIL;
                        pkt_done = 1'b1;
                        state_d  = ST_HEAD;
                    end else begin
                        type_d   = FT_BODY;
                        remain_d = remain_q - LEN_W'(1);
                    end
                end
                default: begin
                    state_d = ST_HEAD;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_HEAD;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    // Clearing rd_q on reset drops the word of an in-flight read; no partial tail is sent.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_q        <= 1'b0;
            flit_out    <= '0;
            flit_valid  <= 1'b0;
            flit_type_q <= FT_BODY;
            pkt_count   <= '0;
        end else begin
            rd_q       <= fifo_rd_en;
            flit_valid <= rd_q;
            if (rd_q) begin
                flit_out    <= fifo_data;
                flit_type_q <= type_d;
            end
            if (pkt_done) begin
                pkt_count <= pkt_count + PKT_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            credits    <= CREDIT_MAX;
            credit_err <= 1'b0;
        end else begin
            case ({fifo_rd_en, credit_in})
                2'b10: credits <= credits - CW'(1);
                2'b01: begin
                    if (credits == CREDIT_MAX) begin
                        credit_err <= 1'b1;
                    end else begin
                        credits <= credits + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ni_flit_injector.sv
// tb_ni_flit_injector: directed and randomized checks of ni_flit_injector against a
// packet-level reference model with a queue-based FIFO source.
module tb_ni_flit_injector;

    localparam int DW      = 32;
    localparam int CREDITS = 4;
    localparam int CW      = 3;
    localparam int LEN_W   = 8;
    localparam int PCW     = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            en = 1'b0;
    logic            fifo_empty = 1'b1;
    logic [DW-1:0]   fifo_data = '0;
    logic            fifo_rd_en;
    logic            credit_in = 1'b0;
    logic [DW-1:0]   flit_out;
    logic            flit_valid;
    logic [1:0]      flit_type;
    logic [CW-1:0]   credits;
    logic            credit_err;
    logic            busy;
    logic [PCW-1:0]  pkt_count;

    always #5 clk = ~clk;

    ni_flit_injector #(
        .DATA_WIDTH(DW), .CREDITS(CREDITS), .CW(CW), .LEN_W(LEN_W), .PKT_CNT_W(PCW)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en), .credit_in(credit_in), .flit_out(flit_out),
        .flit_valid(flit_valid), .flit_type(flit_type), .credits(credits),
        .credit_err(credit_err), .busy(busy), .pkt_count(pkt_count)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // FIFO contents and observed flit log ({type, data})
    logic [DW-1:0] src[$];
    logic [33:0]   flits[$];
    int            rd_seen = 0;

    // Reference model: packet-level view
    int             m_credits = CREDITS;
    bit             m_err = 1'b0;
    logic [PCW-1:0] m_pkt = '0;
    int             words_left = 0;
    bit             m_inflight = 1'b0;
    logic [DW-1:0]  m_word = '0;
    bit             m_valid = 1'b0;
    logic [DW-1:0]  m_out = '0;
    logic [1:0]     m_type = 2'b00;

    task automatic model_edge(input bit rst_v, input bit ci_v, input bit rd_v);
        int len;
        if (!rst_v) begin
            m_credits  = CREDITS;
            m_err      = 1'b0;
            m_pkt      = '0;
            words_left = 0;
            m_inflight = 1'b0;
            m_valid    = 1'b0;
            m_out      = '0;
            m_type     = 2'b00;
            return;
        end
        m_valid = 1'b0;
        if (m_inflight) begin
            m_valid = 1'b1;
            m_out   = m_word;
            if (words_left == 0) begin
                len = int'(m_word >> (DW - LEN_W));
                if (len == 0) begin
                    m_type = 2'b11;
                    m_pkt  = m_pkt + 1'b1;
                end else begin
                    m_type     = 2'b01;
                    words_left = len;
                end
            end else begin
                words_left = words_left - 1;
                if (words_left == 0) begin
                    m_type = 2'b10;
                    m_pkt  = m_pkt + 1'b1;
                end else begin
                    m_type = 2'b00;
                end
            end
        end
        m_inflight = rd_v;
        if (rd_v) m_word = src[0];
        if (rd_v && !ci_v) m_credits = m_credits - 1;
        else if (ci_v && !rd_v) begin
            if (m_credits == CREDITS) m_err = 1'b1;
            else m_credits = m_credits + 1;
        end
    endtask

    // One clock cycle: drive inputs, check read issue, advance, check outputs.
    task automatic cycle(input bit rst_v, input bit en_v, input bit ci_v);
        bit   exp_rd;
        logic dut_rd;
        reset      = rst_v;
        en         = en_v;
        credit_in  = ci_v;
        fifo_empty = (src.size() == 0);
        #1;
        exp_rd = rst_v && en_v && (src.size() != 0) && (m_credits != 0);
        dut_rd = fifo_rd_en;
        check("fifo_rd_en", dut_rd, exp_rd);
        model_edge(rst_v, ci_v, exp_rd);
        @(posedge clk);
        #1;
        if (dut_rd === 1'b1) begin
            rd_seen++;
            if (src.size() != 0) fifo_data = src.pop_front();
        end
        @(negedge clk);
        check("flit_valid", flit_valid, m_valid);
        check("flit_out", flit_out, m_out);
        if (m_valid) check("flit_type", flit_type, m_type);
        check("credits", credits, m_credits);
        check("credit_err", credit_err, m_err);
        check("pkt_count", pkt_count, m_pkt);
        check("busy", busy, (words_left != 0) || m_inflight);
        if (flit_valid === 1'b1) flits.push_back({flit_type, flit_out});
    endtask

    task automatic run(input int n, input bit en_v);
        for (int i = 0; i < n; i++) cycle(1'b1, en_v, 1'b0);
    endtask

    task automatic give_credits(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        int          rd_base;
        logic [7:0]  len_b;
        logic [23:0] low_b;
        bit          r_rst;
        bit          r_en;
        bit          r_ci;

        // Reset state
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        check("reset_credits", credits, CREDITS);
        check("reset_valid", flit_valid, 1'b0);

        // Two-flit packet
        flits.delete();
        src.push_back(32'h0101A5A5);
        src.push_back(32'h0000BBBB);
        rd_base = rd_seen;
        run(6, 1'b1);
        check("t1_reads", rd_seen - rd_base, 2);
        check("t1_credits", credits, 2);
        check("t1_nflits", flits.size(), 2);
        if (flits.size() == 2) begin
            check("t1_head", flits[0], {2'b01, 32'h0101A5A5});
            check("t1_tail", flits[1], {2'b10, 32'h0000BBBB});
        end
        check("t1_pkts", pkt_count, 1);
        give_credits(2);

        // Single-flit packet
        flits.delete();
        src.push_back(32'h00010001);
        run(4, 1'b1);
        check("t2_nflits", flits.size(), 1);
        if (flits.size() == 1) check("t2_flit", flits[0], {2'b11, 32'h00010001});
        check("t2_pkts", pkt_count, 2);
        give_credits(1);

        // Credit starvation with a 6-flit packet
        flits.delete();
        src.push_back(32'h05000000);
        for (int i = 1; i <= 5; i++) src.push_back(32'h00B0D000 + i);
        rd_base = rd_seen;
        run(8, 1'b1);
        check("t3_reads_stall", rd_seen - rd_base, 4);
        check("t3_credits_zero", credits, 0);
        cycle(1'b1, 1'b1, 1'b1);
        run(4, 1'b1);
        check("t3_reads_one", rd_seen - rd_base, 5);
        if (flits.size() == 5) check("t3_body", flits[4], {2'b00, 32'h00B0D004});
        cycle(1'b1, 1'b1, 1'b1);
        run(4, 1'b1);
        check("t3_reads_two", rd_seen - rd_base, 6);
        if (flits.size() == 6) check("t3_tail", flits[5], {2'b10, 32'h00B0D005});
        give_credits(4);

        // Simultaneous credit return and read
        for (int i = 0; i < 4; i++) src.push_back(32'h00000010 + i);
        run(2, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        check("t4_credits", credits, 2);
        run(4, 1'b1);
        give_credits(3);

        // Credit overflow is sticky
        give_credits(1);
        check("t5_credits", credits, CREDITS);
        run(3, 1'b0);
        check("t5_err", credit_err, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        check("t5_err_clear", credit_err, 1'b0);

        // Reset with a read in flight
        flits.delete();
        src.push_back(32'h0100CCCC);
        src.push_back(32'h00010001);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        check("t6_credits", credits, CREDITS);
        check("t6_busy", busy, 1'b0);
        run(4, 1'b1);
        check("t6_nflits", flits.size(), 1);
        if (flits.size() == 1) check("t6_flit", flits[0], {2'b11, 32'h00010001});
        give_credits(1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 35 && src.size() < 8) begin
                len_b = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255))
                                                     : 8'($urandom_range(0, 3));
                low_b = 24'($urandom());
                src.push_back({len_b, low_b});
            end
            r_rst = ($urandom_range(0, 299) != 0);
            r_en  = ($urandom_range(0, 9) < 8);
            r_ci  = ((m_credits < CREDITS) && ($urandom_range(0, 9) < 4)) ||
                    ($urandom_range(0, 199) == 0);
            cycle(r_rst, r_en, r_ci);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
